// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, owner ids, default width.
// No logic of its own, so no latency.
// Backpressure is not applicable here; the arbiter and picker use these definitions.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between the fetch and MEM-stage requesters (MEM_ARB_ROUND_ROBIN_EN picks alternation).
// Purely combinational, so it adds 0 cycles of latency.
// Backpressure is not applicable; the caller only samples the grant while its FSM is idle.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   inst_req,
    input  logic   data_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  owner_t last_owner,
`endif
    output logic   gnt_vld,
    output owner_t gnt_owner
);

    always_comb begin
        gnt_vld   = inst_req | data_req;
        gnt_owner = OWN_INST;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        // On a tie, the side that did not win last time gets the grant.
        if (inst_req && data_req) begin
            gnt_owner = (last_owner == OWN_INST) ? OWN_DATA : OWN_INST;
        end else if (data_req) begin
            gnt_owner = OWN_DATA;
        end
`else
        if (data_req) begin
            gnt_owner = OWN_DATA;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and MEM-stage requests onto one SRAM-like bus, one transaction at a time (MEM_ARB_ROUND_ROBIN_EN selects round-robin).
// Latency is at least 3 cycles from request to done (IDLE -> REQ -> WAIT -> DONE).
// Backpressure: bus_req is held with stable fields until bus_addr_ok; requesters hold their request until done.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [ADDR_W-1:0] inst_rdata,
    output logic              inst_done,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [ADDR_W-1:0] data_wdata,
    output logic [ADDR_W-1:0] data_rdata,
    output logic              data_done,

    input  logic              flush,

    output logic              bus_req,
    output logic              bus_wr,
    output logic [3:0]        bus_wstrb,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [ADDR_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [ADDR_W-1:0] bus_rdata,

    output logic              stallreq_if,
    output logic              stallreq_mem
);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic              wr_q, wr_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wdata_q, wdata_d;
    logic              discard_q, discard_d;
    logic [ADDR_W-1:0] inst_rdata_q, inst_rdata_d;
    logic [ADDR_W-1:0] data_rdata_q, data_rdata_d;

    logic              gnt_vld;
    owner_t            gnt_owner;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_t            rr_q, rr_d;
`endif

    mem_arb_pick u_pick (
        .inst_req   (inst_req),
        .data_req   (data_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last_owner (rr_q),
`endif
        .gnt_vld    (gnt_vld),
        .gnt_owner  (gnt_owner)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        wr_d         = wr_q;
        wstrb_d      = wstrb_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        discard_d    = discard_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        rr_d         = rr_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    state_d   = ST_REQ;
                    owner_d   = gnt_owner;
                    discard_d = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    rr_d      = gnt_owner;
`endif
                    if (gnt_owner == OWN_DATA) begin
                        wr_d    = data_wr;
                        wstrb_d = data_wstrb;
                        addr_d  = data_addr;
                        wdata_d = data_wdata;
                    end else begin
                        wr_d    = 1'b0;
                        wstrb_d = 4'b0000;
                        addr_d  = inst_addr;
                        wdata_d = '0;
                    end
                end
            end
            ST_REQ: begin
                // A flushed fetch still runs to completion on the bus; only its result is dropped.
                if (flush && owner_q == OWN_INST) begin
                    discard_d = 1'b1;
                end
                if (bus_addr_ok) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush && owner_q == OWN_INST) begin
                    discard_d = 1'b1;
                end
                if (bus_data_ok) begin
                    state_d = ST_DONE;
                    if (owner_q == OWN_INST) begin
                        inst_rdata_d = bus_rdata;
                    end else if (!wr_q) begin
                        data_rdata_d = bus_rdata;
                    end
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                discard_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_INST;
            wr_q         <= 1'b0;
            wstrb_q      <= 4'b0000;
            addr_q       <= '0;
            wdata_q      <= '0;
            discard_q    <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_q         <= OWN_INST;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            wr_q         <= wr_d;
            wstrb_q      <= wstrb_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            discard_q    <= discard_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_q         <= rr_d;
`endif
        end
    end

    assign bus_req      = (state_q == ST_REQ);
    assign bus_wr       = wr_q;
    assign bus_wstrb    = wstrb_q;
    assign bus_addr     = addr_q;
    assign bus_wdata    = wdata_q;

    assign inst_rdata   = inst_rdata_q;
    assign data_rdata   = data_rdata_q;
    // A flush arriving in the DONE cycle itself also hides the fetch result.
    assign inst_done    = (state_q == ST_DONE) && (owner_q == OWN_INST) && !discard_q && !flush;
    assign data_done    = (state_q == ST_DONE) && (owner_q == OWN_DATA);

    assign stallreq_if  = inst_req & ~inst_done;
    assign stallreq_mem = data_req & ~data_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a bus responder with programmable delays, requester drivers, per-scenario tasks.
// Also builds with MEM_ARB_ROUND_ROBIN_EN defined, where the held-request grant pattern is expected to alternate.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    typedef struct {
        owner_t      own;
        logic [31:0] rdata;
        logic        chk;
    } exp_t;

    typedef struct {
        owner_t      own;
        logic [31:0] rdata;
        int          cyc;
    } done_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        int          cyc;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_done;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_done;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        flush;
    logic        bus_req, bus_wr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;
    logic        stallreq_if, stallreq_mem;

    exp_t  exp_q[$];
    done_t done_q[$];
    bus_t  bus_q[$];

    int cyc = 0;
    int passed = 0;
    int total = 0;
    int addr_dly = 0;
    int data_dly = 0;
    int dok_cnt = 0;
    bit force_dok = 1'b0;
    bit hold = 1'b0;

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_done(inst_done),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_done(data_done),
        .flush(flush),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata),
        .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
    );

    always #5 clk = ~clk;

    initial forever @(posedge clk) cyc++;

    // Memory contents seen through the bus: chosen so 0xBFC00000 reads back 0x24020001.
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return a ^ 32'h9BC2_0001;
    endfunction

    // SRAM-like slave: samples at negedge, drives 2 ns later.
    initial begin : bus_model
        int          phase;
        int          cnt;
        logic [31:0] cur;
        logic        aok, dok;
        bus_t        b;
        phase = 0; cnt = 0; cur = '0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
        forever begin
            @(negedge clk);
            aok = 1'b0; dok = 1'b0;
            if (rst) begin
                phase = 0; cnt = 0;
            end else if (phase == 0) begin
                if (bus_req) begin
                    if (cnt >= addr_dly) begin
                        aok = 1'b1; cur = bus_addr; phase = 1; cnt = 0;
                        b.wr = bus_wr; b.addr = bus_addr; b.wstrb = bus_wstrb;
                        b.wdata = bus_wdata; b.cyc = cyc;
                        bus_q.push_back(b);
                    end else begin
                        cnt++;
                    end
                end else begin
                    cnt = 0;
                end
            end else begin
                if (cnt >= data_dly) begin
                    dok = 1'b1; phase = 0; cnt = 0; dok_cnt++;
                end else begin
                    cnt++;
                end
            end
            #2;
            bus_addr_ok = aok;
            bus_data_ok = dok | force_dok;
            if (dok) bus_rdata = mem_val(cur);
            else if (force_dok) bus_rdata = 32'hDEAD_BEEF;
        end
    end

    // One cycle: record done pulses at negedge, then let requesters drop on done.
    task automatic step();
        done_t d;
        logic  id, dd;
        @(negedge clk);
        id = inst_done;
        dd = data_done;
        if (id) begin d.own = OWN_INST; d.rdata = inst_rdata; d.cyc = cyc; done_q.push_back(d); end
        if (dd) begin d.own = OWN_DATA; d.rdata = data_rdata; d.cyc = cyc; done_q.push_back(d); end
        #1;
        if (!hold) begin
            if (id) inst_req = 1'b0;
            if (dd) data_req = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0;
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
        repeat (3) step();
        rst = 1'b0;
        step();
        total++;
        if ({bus_req, inst_done, data_done, stallreq_if, stallreq_mem} !== 5'b0)
            $display("FAIL reset_ctl: got %b, want 00000",
                     {bus_req, inst_done, data_done, stallreq_if, stallreq_mem});
        else passed++;
        total++;
        if (inst_rdata !== 32'h0) $display("FAIL reset_inst_rdata: got %h, want 0", inst_rdata);
        else passed++;
        total++;
        if (data_rdata !== 32'h0) $display("FAIL reset_data_rdata: got %h, want 0", data_rdata);
        else passed++;
    endtask

    task automatic test_inst_only();
        int    t0;
        exp_t  e;
        done_t d;
        addr_dly = 0; data_dly = 0;
        step();
        inst_addr = 32'hBFC0_0000; inst_req = 1'b1; t0 = cyc;
        e.own = OWN_INST; e.rdata = mem_val(32'hBFC0_0000); e.chk = 1'b1; exp_q.push_back(e);
        step();
        total++;
        if (stallreq_if !== 1'b1) $display("FAIL inst_stall_hi: got %b, want 1", stallreq_if);
        else passed++;
        for (int i = 0; i < 20 && done_q.size() < exp_q.size(); i++) step();
        total++;
        if (done_q.size() == 0 || done_q[0].cyc - t0 != 3 || done_q[0].rdata !== 32'h2402_0001)
            $display("FAIL inst_latency: got n=%0d lat=%0d rdata=%h, want lat=3 rdata=24020001",
                     done_q.size(), (done_q.size() > 0) ? done_q[0].cyc - t0 : -1,
                     (done_q.size() > 0) ? done_q[0].rdata : 32'h0);
        else passed++;
        while (exp_q.size() > 0 && done_q.size() > 0) begin
            e = exp_q.pop_front(); d = done_q.pop_front(); total++;
            if (d.own !== e.own || (e.chk && d.rdata !== e.rdata))
                $display("FAIL inst_sb: got own=%0d rdata=%h, want own=%0d rdata=%h", d.own, d.rdata, e.own, e.rdata);
            else passed++;
        end
        step();
        total++;
        if (stallreq_if !== 1'b0 || exp_q.size() != 0 || done_q.size() != 0)
            $display("FAIL inst_after: got stall=%b exp=%0d done=%0d, want 0 0 0", stallreq_if, exp_q.size(), done_q.size());
        else passed++;
        exp_q.delete(); done_q.delete();
    endtask

    task automatic test_priority();
        int    nb, first_inst;
        exp_t  e;
        done_t d;
        step();
        nb = bus_q.size(); first_inst = -1;
        inst_addr = 32'hBFC0_0040; inst_req = 1'b1;
        data_addr = 32'h8000_0010; data_wr = 1'b0; data_wstrb = 4'b0000; data_req = 1'b1;
        e.own = OWN_DATA; e.rdata = mem_val(32'h8000_0010); e.chk = 1'b1; exp_q.push_back(e);
        e.own = OWN_INST; e.rdata = mem_val(32'hBFC0_0040); e.chk = 1'b1; exp_q.push_back(e);
        for (int i = 0; i < 30 && done_q.size() < exp_q.size(); i++) begin
            step();
            if (bus_req && bus_addr == 32'hBFC0_0040 && first_inst < 0) first_inst = cyc;
        end
        total++;
        if (bus_q.size() < nb + 2 || bus_q[nb].addr !== 32'h8000_0010 || bus_q[nb + 1].addr !== 32'hBFC0_0040)
            $display("FAIL pri_order: got n=%0d first=%h, want 80000010 then bfc00040",
                     bus_q.size() - nb, (bus_q.size() > nb) ? bus_q[nb].addr : 32'h0);
        else passed++;
        total++;
        if (done_q.size() == 0 || done_q[0].own !== OWN_DATA || first_inst < 0 || done_q[0].cyc >= first_inst)
            $display("FAIL pri_done_first: got data_done_cyc=%0d inst_req_cyc=%0d, want data first",
                     (done_q.size() > 0) ? done_q[0].cyc : -1, first_inst);
        else passed++;
        while (exp_q.size() > 0 && done_q.size() > 0) begin
            e = exp_q.pop_front(); d = done_q.pop_front(); total++;
            if (d.own !== e.own || (e.chk && d.rdata !== e.rdata))
                $display("FAIL pri_sb: got own=%0d rdata=%h, want own=%0d rdata=%h", d.own, d.rdata, e.own, e.rdata);
            else passed++;
        end
        total++;
        if (exp_q.size() != 0 || done_q.size() != 0)
            $display("FAIL pri_left: got exp=%0d done=%0d, want 0 0", exp_q.size(), done_q.size());
        else passed++;
        exp_q.delete(); done_q.delete();
    endtask

    task automatic test_store_delay();
        int nb, hi, bad;
        addr_dly = 4;
        step();
        nb = bus_q.size(); hi = 0; bad = 0;
        data_addr = 32'h8000_0020; data_wr = 1'b1; data_wstrb = 4'b0011;
        data_wdata = 32'hCAFE_F00D; data_req = 1'b1;
        for (int i = 0; i < 30 && done_q.size() == 0; i++) begin
            step();
            if (bus_req) begin
                hi++;
                if (bus_addr !== 32'h8000_0020 || bus_wstrb !== 4'b0011 || bus_wr !== 1'b1 || bus_wdata !== 32'hCAFE_F00D)
                    bad++;
            end
        end
        repeat (4) step();
        total++;
        if (hi != 5 || bad != 0) $display("FAIL store_hold: got cycles=%0d unstable=%0d, want 5 0", hi, bad);
        else passed++;
        total++;
        if (done_q.size() != 1 || done_q[0].own !== OWN_DATA)
            $display("FAIL store_done: got n=%0d, want one data_done", done_q.size());
        else passed++;
        total++;
        if (bus_q.size() != nb + 1 || bus_q[nb].wr !== 1'b1 || bus_q[nb].wstrb !== 4'b0011)
            $display("FAIL store_bus: got n=%0d, want 1 write wstrb=0011", bus_q.size() - nb);
        else passed++;
        done_q.delete();
        addr_dly = 0; data_wr = 1'b0; data_wstrb = 4'b0000;
    endtask

    task automatic test_flush_inst();
        int    nb, dok0, t0;
        bit    seen, flushed;
        exp_t  e;
        done_t d;
        data_dly = 2;
        step();
        nb = bus_q.size(); dok0 = dok_cnt; seen = 0; flushed = 0;
        inst_addr = 32'hBFC0_0080; inst_req = 1'b1;
        for (int i = 0; i < 20 && !flushed; i++) begin
            step();
            if (bus_req) seen = 1;
            else if (seen) begin flush = 1'b1; inst_req = 1'b0; flushed = 1; end
        end
        step();
        flush = 1'b0;
        repeat (8) step();
        total++;
        if (done_q.size() != 0) $display("FAIL flush_no_done: got %0d done pulses, want 0", done_q.size());
        else passed++;
        total++;
        if (dok_cnt != dok0 + 1 || bus_q.size() != nb + 1)
            $display("FAIL flush_bus: got data_ok=%0d accepts=%0d, want 1 1", dok_cnt - dok0, bus_q.size() - nb);
        else passed++;
        data_dly = 0; done_q.delete();
        data_addr = 32'h8000_0030; data_wr = 1'b0; data_req = 1'b1; t0 = cyc;
        e.own = OWN_DATA; e.rdata = mem_val(32'h8000_0030); e.chk = 1'b1; exp_q.push_back(e);
        for (int i = 0; i < 20 && done_q.size() < exp_q.size(); i++) step();
        total++;
        if (done_q.size() == 0 || done_q[0].cyc - t0 != 3)
            $display("FAIL flush_idle: got lat=%0d, want 3", (done_q.size() > 0) ? done_q[0].cyc - t0 : -1);
        else passed++;
        while (exp_q.size() > 0 && done_q.size() > 0) begin
            e = exp_q.pop_front(); d = done_q.pop_front(); total++;
            if (d.own !== e.own || (e.chk && d.rdata !== e.rdata))
                $display("FAIL flush_sb: got own=%0d rdata=%h, want own=%0d rdata=%h", d.own, d.rdata, e.own, e.rdata);
            else passed++;
        end
        exp_q.delete(); done_q.delete();
    endtask

    task automatic test_flush_done_and_data();
        exp_t  e;
        done_t d;
        step();
        inst_addr = 32'hBFC0_00A0; inst_req = 1'b1;
        step(); step();
        @(posedge clk);
        #1 flush = 1'b1;
        step();
        flush = 1'b0; inst_req = 1'b0;
        repeat (5) step();
        total++;
        if (done_q.size() != 0) $display("FAIL flush_in_done: got %0d done pulses, want 0", done_q.size());
        else passed++;
        done_q.delete();
        data_addr = 32'h8000_0040; data_wr = 1'b0; data_req = 1'b1; flush = 1'b1;
        e.own = OWN_DATA; e.rdata = mem_val(32'h8000_0040); e.chk = 1'b1; exp_q.push_back(e);
        for (int i = 0; i < 20 && done_q.size() < exp_q.size(); i++) step();
        flush = 1'b0;
        total++;
        if (done_q.size() != 1) $display("FAIL flush_data_n: got %0d, want 1", done_q.size());
        else passed++;
        while (exp_q.size() > 0 && done_q.size() > 0) begin
            e = exp_q.pop_front(); d = done_q.pop_front(); total++;
            if (d.own !== e.own || (e.chk && d.rdata !== e.rdata))
                $display("FAIL flush_data_sb: got own=%0d rdata=%h, want own=%0d rdata=%h", d.own, d.rdata, e.own, e.rdata);
            else passed++;
        end
        exp_q.delete(); done_q.delete();
    endtask

    task automatic test_reset_wait();
        int    hi, t0;
        bit    seen, inwait;
        exp_t  e;
        done_t d;
        data_dly = 50;
        step();
        seen = 0; inwait = 0;
        inst_addr = 32'hBFC0_00C0; inst_req = 1'b1;
        for (int i = 0; i < 20 && !inwait; i++) begin
            step();
            if (bus_req) seen = 1;
            else if (seen) inwait = 1;
        end
        rst = 1'b1; inst_req = 1'b0;
        step();
        total++;
        if (bus_req !== 1'b0 || inst_rdata !== 32'h0)
            $display("FAIL rst_wait: got bus_req=%b inst_rdata=%h, want 0 0", bus_req, inst_rdata);
        else passed++;
        rst = 1'b0; force_dok = 1'b1;
        step(); step();
        force_dok = 1'b0;
        hi = 0;
        repeat (5) begin step(); if (bus_req) hi++; end
        total++;
        if (done_q.size() != 0 || hi != 0)
            $display("FAIL rst_late_ok: got done=%0d bus_req_cycles=%0d, want 0 0", done_q.size(), hi);
        else passed++;
        data_dly = 0; done_q.delete();
        inst_addr = 32'hBFC0_0000; inst_req = 1'b1; t0 = cyc;
        e.own = OWN_INST; e.rdata = 32'h2402_0001; e.chk = 1'b1; exp_q.push_back(e);
        for (int i = 0; i < 20 && done_q.size() < exp_q.size(); i++) step();
        total++;
        if (done_q.size() == 0 || done_q[0].cyc - t0 != 3)
            $display("FAIL rst_idle: got lat=%0d, want 3", (done_q.size() > 0) ? done_q[0].cyc - t0 : -1);
        else passed++;
        while (exp_q.size() > 0 && done_q.size() > 0) begin
            e = exp_q.pop_front(); d = done_q.pop_front(); total++;
            if (d.own !== e.own || (e.chk && d.rdata !== e.rdata))
                $display("FAIL rst_sb: got own=%0d rdata=%h, want own=%0d rdata=%h", d.own, d.rdata, e.own, e.rdata);
            else passed++;
        end
        exp_q.delete(); done_q.delete();
    endtask

    task automatic test_back_to_back();
        int          nb;
        logic [31:0] want [4];
`ifdef MEM_ARB_ROUND_ROBIN_EN
        want = '{32'h8000_0100, 32'hBFC0_0100, 32'h8000_0100, 32'hBFC0_0100};
`else
        want = '{32'h8000_0100, 32'h8000_0100, 32'h8000_0100, 32'h8000_0100};
`endif
        step();
        nb = bus_q.size(); hold = 1'b1;
        inst_addr = 32'hBFC0_0100; inst_req = 1'b1;
        data_addr = 32'h8000_0100; data_wr = 1'b0; data_req = 1'b1;
        repeat (24) step();
        inst_req = 1'b0; data_req = 1'b0; hold = 1'b0;
        repeat (8) step();
        total++;
        if (bus_q.size() < nb + 4) $display("FAIL b2b_count: got %0d grants, want >=4", bus_q.size() - nb);
        else passed++;
        for (int k = 0; k < 4; k++) begin
            if (bus_q.size() > nb + k) begin
                total++;
                if (bus_q[nb + k].addr !== want[k])
                    $display("FAIL b2b_grant%0d: got %h, want %h", k, bus_q[nb + k].addr, want[k]);
                else passed++;
            end
        end
        done_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: sim time limit reached, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_inst_only();
        test_priority();
        test_store_delay();
        test_flush_inst();
        test_flush_done_and_data();
        test_reset_wait();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address/data width of both requester ports and the bus port.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 inst_req / inst_addr  in  1/ADDR_W  fetch read request, held until inst_done.
REQ-005 inst_rdata / inst_done  out  ADDR_W/1  fetch data, valid in the single cycle inst_done=1.
REQ-006 data_req / data_wr / data_wstrb / data_addr / data_wdata  in  1/1/4/ADDR_W/ADDR_W  MEM-stage request, held until data_done.
REQ-007 data_rdata / data_done  out  ADDR_W/1  load data, valid in the single cycle data_done=1.
REQ-008 flush  in  1  exception/branch flush pulse, discards the in-flight fetch result.
REQ-009 bus_req / bus_wr / bus_wstrb / bus_addr / bus_wdata  out  1/1/4/ADDR_W/ADDR_W  shared SRAM-like request.
REQ-010 bus_addr_ok / bus_data_ok / bus_rdata  in  1/1/ADDR_W  bus address accept, data return, read data.
REQ-011 stallreq_if / stallreq_mem  out  1/1  stall requests to ctrl.

Function
REQ-012 FSM states IDLE, REQ, WAIT, DONE; one transaction outstanding at a time.
REQ-013 IDLE: any request pending -> latch grant owner and its request fields, go REQ; none -> stay IDLE.
REQ-014 Fixed priority (macro absent): data beats inst when both pending in IDLE.
REQ-015 REQ: bus_req=1 with latched fields; bus_addr_ok=1 -> WAIT, else hold all bus outputs stable.
REQ-016 WAIT: bus_req=0; bus_data_ok=1 -> latch bus_rdata into the owner's rdata register, go DONE.
REQ-017 DONE: owner's done=1 for exactly this cycle; next state IDLE unconditionally; requests not sampled in DONE.
REQ-018 Minimum latency req->done = 3 cycles (addr_ok in first REQ cycle, data_ok in first WAIT cycle).
REQ-019 For writes, data_rdata is don't-care; data_done still pulses.
REQ-020 stallreq_if = inst_req & ~inst_done; stallreq_mem = data_req & ~data_done (combinational).
REQ-021 flush while owner=inst in REQ or WAIT: set discard flag; transaction still completes on bus; inst_done suppressed in DONE.
REQ-022 flush in DONE with owner=inst: inst_done suppressed that cycle.
REQ-023 flush never cancels or alters a data-owner transaction.
REQ-024 bus_addr_ok/bus_data_ok outside REQ/WAIT respectively are ignored.
REQ-025 Request dropped by requester mid-transaction: transaction still completes; done pulse still issued (unless REQ-021).

Reset
REQ-026 rst=1 at edge: state IDLE, bus_req=0, inst_done=0, data_done=0, discard=0, rdata registers 0, RR pointer = inst, regardless of current state.

Configuration
REQ-027 MEM_ARB_ROUND_ROBIN_EN defined: when both pending in IDLE, grant goes to the requester not granted last; pointer updates on each grant.
REQ-028 MEM_ARB_ROUND_ROBIN_EN undefined: REQ-014 fixed priority, no pointer register.

Structure
REQ-029 Package mem_arb_pkg: FSM state encoding, owner constants (OWN_INST, OWN_DATA), ADDR_W default.
REQ-030 One sub-module mem_arb_pick: combinational grant selection from both requests plus RR pointer.

Verification
REQ-031 Inst only, addr_ok and data_ok immediate, bus_rdata=0x24020001 -> inst_done in cycle 3, inst_rdata=0x24020001, stallreq_if low thereafter.
REQ-032 Inst and data_req (load, addr 0x80000010) same cycle, fixed priority -> bus_addr=0x80000010 first, data_done before any inst bus_req.
REQ-033 Store wstrb=4'b0011, addr_ok delayed 4 cycles -> bus_req/bus_addr/bus_wstrb stable 5 cycles, data_done once.
REQ-034 Flush during inst WAIT -> bus transaction completes, no inst_done, FSM IDLE next cycle after DONE.
REQ-035 rst in WAIT -> bus_req=0 and state IDLE next cycle; late bus_data_ok ignored, no done pulse.
REQ-036 MEM_ARB_ROUND_ROBIN_EN, both requests held continuously -> grants alternate data, inst, data, inst.
